// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encrypt sequencer driving an external combinational round function.
// Latency: 11 cycles from accept to out_valid; one block per 11 cycles when streaming.
// Backpressure: ciphertext held in DONE until out_ready; in_ready tracks out_ready there.
module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_pt,
    input  logic [127:0] in_key,
    output logic [127:0] rnd_state_in,
    output logic [127:0] rnd_key_in,
    output logic [7:0]   rnd_rcon,
    output logic         rnd_last,
    input  logic [127:0] rnd_state_out,
    input  logic [127:0] rnd_key_out,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_ct
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t       r_fsm;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic         r_out_vld;

    logic         w_in_rdy;
    logic         w_accept;
    logic         w_in_round;
    logic [7:0]   w_rcon_nxt;

    assign w_in_round = (r_fsm == S_ROUND);
    assign w_in_rdy   = (r_fsm == S_IDLE) | ((r_fsm == S_DONE) & out_ready);
    assign w_accept   = in_valid & w_in_rdy;
    assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm     <= S_IDLE;
            r_round   <= 4'd0;
            r_rcon    <= 8'h01;
            r_state   <= 128'd0;
            r_key     <= 128'd0;
            r_out_vld <= 1'b0;
        end else if (w_accept) begin
            // Accept is only possible in IDLE or in DONE while the ciphertext drains.
            r_fsm     <= S_ROUND;
            r_round   <= 4'd1;
            r_rcon    <= 8'h01;
            r_state   <= in_pt ^ in_key;
            r_key     <= in_key;
            r_out_vld <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_fsm <= S_IDLE;
                end
                S_ROUND: begin
                    r_state <= rnd_state_out;
                    r_key   <= rnd_key_out;
                    if (r_round == 4'd10) begin
                        r_fsm     <= S_DONE;
                        r_out_vld <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                        r_rcon  <= w_rcon_nxt;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_fsm     <= S_IDLE;
                        r_out_vld <= 1'b0;
                    end
                end
                default: begin
                    r_fsm     <= S_IDLE;
                    r_out_vld <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = w_in_rdy;
    assign rnd_state_in = r_state;
    assign rnd_key_in   = r_key;
    assign rnd_rcon     = r_rcon;
    assign rnd_last     = w_in_round & (r_round == 4'd10);

    // Key-schedule tap: cipher key on accept, freshly expanded key in every round.
    assign rk_valid = w_accept | w_in_round;
    assign rk_idx   = w_in_round ? r_round : 4'd0;
    assign rk_out   = w_in_round ? rnd_key_out : in_key;

    assign out_valid = r_out_vld;
    assign out_ct    = r_state;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption sequencer. Owns the 128-bit state and round-key registers and steps an external combinational round function through the ten AES-128 rounds. Generates round index and Rcon, and buffers the ciphertext behind a valid/ready handshake. Exposes each round key as it is produced so on-chip monitors can tap the key schedule. Sits between the host-facing block interface and the round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey plus one key-expansion step).

## Interface
- No parameters; fixed to AES-128 with 10 rounds.
- clk  in  1  single clock; all flops rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  controller can accept a block.
- in_pt  in  128  plaintext, bit 127 = first byte MSB.
- in_key  in  128  cipher key.
- rnd_state_in  out  128  state register to round function.
- rnd_key_in  out  128  previous round key to round function.
- rnd_rcon  out  8  Rcon for current round.
- rnd_last  out  1  high in round 10; datapath skips MixColumns.
- rnd_state_out  in  128  state after current round, using rnd_key_out.
- rnd_key_out  in  128  round key for current round.
- rk_valid  out  1  one-cycle pulse per round key written.
- rk_idx  out  4  index of key on rk_out, 0..10.
- rk_out  out  128  round key just written.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_ct  out  128  ciphertext.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - state_reg <= in_pt ^ in_key.
  - key_reg <= in_key.
  - round <= 1, rcon <= 8'h01.
  - rk_valid pulse with rk_idx=0, rk_out=in_key.
  - Go to ROUND.
- ROUND: in_ready=0; in_valid ignored. Each cycle:
  - state_reg <= rnd_state_out, key_reg <= rnd_key_out.
  - rk_valid=1, rk_idx=round, rk_out=rnd_key_out, presented combinationally in the same cycle.
  - round <= round+1; rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 0).
  - rnd_last = (round==10). After round 10 go to DONE.
- Rcon sequence, rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- DONE: out_valid=1, out_ct=state_reg, held stable until out_ready.
  - out_valid&out_ready and in_valid both high: the new block is accepted in the same cycle, with the same actions as IDLE. Go to ROUND.
  - out_ready high, in_valid low: go to IDLE.
  - In DONE, in_ready = out_ready.
- rnd_state_in = state_reg and rnd_key_in = key_reg at all times.
- round and rk_idx are 4-bit; round never exceeds 10. Round values 0 and 11..15 are unreachable.

## Timing
- Reset values (async assert, sync release): FSM=IDLE, round=0, rcon=8'h01, state_reg=0, key_reg=0.
  - Outputs: in_ready=1, out_valid=0, rk_valid=0, rk_idx=0, rnd_last=0, out_ct=0.
- Accept at edge T. ROUND occupies cycles T+1..T+10. out_valid rises after edge T+10 and is visible in cycle T+11.
- Latency: 11 cycles from accept to out_valid.
- Throughput with out_ready and in_valid held high: one block every 11 cycles.
- rk_valid pulses:
  - idx 0 in the accept cycle.
  - idx 1..10 in ROUND cycles.
  - Exactly 11 pulses per block, never during DONE or IDLE without accept.
- Reset asserted mid-operation: immediate return to reset values. No out_valid for the aborted block. The next accepted block is processed correctly.
- out_valid, once asserted, never drops without out_ready. out_ct stays stable while stalled.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: out_ct=69c4e0d86a7b0430d8cdb78070b4c55a at cycle T+11.
  - Required: rk_idx=10 with rk_out=13111d7fe3944a17f307a78b4d2b30c5.
- Rcon/last check on the same run: rnd_rcon per round equals 01,02,04,08,10,20,40,80,1B,36. rnd_last is high only in round 10.
- Backpressure: out_ready=0 for 20 cycles after out_valid.
  - Required: out_ct stable, in_ready=0, extra in_valid ignored.
  - Then out_ready=1: one transfer, FSM returns to IDLE.
- Back-to-back: in_valid and out_ready held high for three blocks.
  - Required: out_valid at cycles 11, 22, 33 after first accept.
  - Required: three correct ciphertexts, 33 rk_valid pulses.
- Reset mid-round: assert rst low during round 5.
  - Required: out_valid=0 and in_ready=1 immediately.
  - Required: a following C.1 block still yields 69c4e0d86a7b0430d8cdb78070b4c55a.
- Busy ignore: toggle in_valid with a different key during ROUND. Required: result and rk sequence unchanged.
